// File: rtl/aes_verify_sequencer_if.sv
// Handshake bundle between the AES run sequencer and the platform top, stimulus
// generator, chip under test and scoreboard.
interface aes_verify_sequencer_if;
    logic        start;
    logic [31:0] vec_num;
    logic        gen_next;
    logic        chip_load;
    logic        chip_en;
    logic [31:0] sb_total;
    logic [31:0] sb_correct;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_err;
    logic        spurious_err;
    logic [31:0] sent;

    modport master (
        output start, vec_num, chip_en, sb_total, sb_correct,
        input  gen_next, chip_load, busy, done, pass, timeout_err, spurious_err, sent
    );

    modport slave (
        input  start, vec_num, chip_en, sb_total, sb_correct,
        output gen_next, chip_load, busy, done, pass, timeout_err, spurious_err, sent
    );
endinterface

// File: rtl/aes_verify_sequencer.sv
// Run controller: issues a programmed number of AES encryptions one at a time,
// watches for the chip result strobe and derives a pass/fail verdict from the scoreboard.
module aes_verify_sequencer #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned GEN_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    aes_verify_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GEN    = 3'd1,
        S_SETTLE = 3'd2,
        S_LOAD   = 3'd3,
        S_WAIT   = 3'd4,
        S_DRAIN  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] LAT_LAST     = 32'(GEN_LAT - 1);

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] base_total_q, base_total_d;
    logic [31:0] base_correct_q, base_correct_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] lat_cnt_q, lat_cnt_d;
    logic [31:0] sent_q, sent_d;
    logic        gen_next_q, gen_next_d;
    logic        chip_load_q, chip_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_err_q, timeout_err_d;
    logic        spurious_err_q, spurious_err_d;
    logic        start_ok_s;
    logic        strobe_bad_s;

    // Next-state and next-output computation for the run FSM.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        base_total_d   = base_total_q;
        base_correct_d = base_correct_q;
        timer_d        = timer_q;
        lat_cnt_d      = lat_cnt_q;
        sent_d         = sent_q;
        pass_d         = pass_q;
        timeout_err_d  = timeout_err_q;

        start_ok_s   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
        strobe_bad_s = bus.chip_en && ((state_q == S_GEN) || (state_q == S_SETTLE) ||
                                       (state_q == S_LOAD) || (state_q == S_DRAIN));
        spurious_err_d = spurious_err_q | strobe_bad_s;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_ok_s) begin
                    target_d       = bus.vec_num;
                    base_total_d   = bus.sb_total;
                    base_correct_d = bus.sb_correct;
                    sent_d         = 32'd0;
                    timeout_err_d  = 1'b0;
                    spurious_err_d = 1'b0;
                    if (bus.vec_num == 32'd0) begin
                        state_d = S_DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_GEN;
                        pass_d  = 1'b0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_GEN: begin
                // lat_cnt counts cycles since gen_next; chip_load lands GEN_LAT cycles later.
                lat_cnt_d = 32'd0;
                if (LAT_LAST == 32'd0) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                lat_cnt_d = lat_cnt_q + 32'd1;
                if (lat_cnt_d == LAT_LAST) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_LOAD: begin
                sent_d  = sent_q + 32'd1;
                timer_d = 32'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.chip_en) begin
                    if (sent_q == target_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_GEN;
                    end
                end else begin
                    timer_d = (timer_q == 32'hFFFF_FFFF) ? timer_q : (timer_q + 32'd1);
                    if (timer_q == TIMEOUT_LAST) begin
                        state_d       = S_ERR;
                        timeout_err_d = 1'b1;
                        pass_d        = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_DRAIN: begin
                // Modulo-2^32 deltas tolerate scoreboard counter wrap.
                state_d = S_DONE;
                pass_d  = ((bus.sb_total - base_total_q) == target_q) &&
                          ((bus.sb_correct - base_correct_q) == target_q) &&
                          !spurious_err_d;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gen_next_d  = (state_d == S_GEN);
        chip_load_d = (state_d == S_LOAD);
        busy_d      = (state_d == S_GEN) || (state_d == S_SETTLE) || (state_d == S_LOAD) ||
                      (state_d == S_WAIT) || (state_d == S_DRAIN);
        done_d      = (state_d == S_DONE) || (state_d == S_ERR);
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            target_q       <= 32'd0;
            base_total_q   <= 32'd0;
            base_correct_q <= 32'd0;
            timer_q        <= 32'd0;
            lat_cnt_q      <= 32'd0;
            sent_q         <= 32'd0;
            gen_next_q     <= 1'b0;
            chip_load_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            base_total_q   <= base_total_d;
            base_correct_q <= base_correct_d;
            timer_q        <= timer_d;
            lat_cnt_q      <= lat_cnt_d;
            sent_q         <= sent_d;
            gen_next_q     <= gen_next_d;
            chip_load_q    <= chip_load_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
        end
    end

    assign bus.gen_next     = gen_next_q;
    assign bus.chip_load    = chip_load_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.spurious_err = spurious_err_q;
    assign bus.sent         = sent_q;

endmodule
